// File: rtl/dma_rd_arb_if.sv
// Control handshake between the read arbiter (master) and the shared DMA read engine (slave).
interface dma_rd_arb_if #(
  parameter int ADDR_WDTH = 32,
  parameter int LEN_WDTH  = 32
);
  logic                 cfg_rsoft_rst;
  logic                 cfg_rstart;
  logic [ADDR_WDTH-1:0] cfg_raddr;
  logic [LEN_WDTH-1:0]  cfg_rlen;
  logic                 cfg_ridle;

  modport master (
    output cfg_rsoft_rst,
    output cfg_rstart,
    output cfg_raddr,
    output cfg_rlen,
    input  cfg_ridle
  );

  modport slave (
    input  cfg_rsoft_rst,
    input  cfg_rstart,
    input  cfg_raddr,
    input  cfg_rlen,
    output cfg_ridle
  );
endinterface

// File: rtl/dma_rd_arb.sv
// Round-robin arbiter sharing one DMA read engine among NUM_REQ requesters, with
// one queued request per slot, idle-handshake completion and a watchdog timeout.
module dma_rd_arb #(
  parameter int NUM_REQ   = 4,
  parameter int LEN_WDTH  = 32,
  parameter int ADDR_WDTH = 32,
  parameter int TMO_WDTH  = 24
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           cfg_rst,
  input  logic [NUM_REQ-1:0]             req_start,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]             req_pend,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [NUM_REQ-1:0]             sts_ovf,
  output logic                           sts_tmo,
  output logic [$clog2(NUM_REQ)-1:0]     sts_gnt_id,
  dma_rd_arb_if.master                   eng
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WBUSY,
    ST_WDONE,
    ST_DONE
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   pend_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   ovf_q;
  logic                 tmo_q;
  logic [ID_W-1:0]      gnt_q;
  logic [ID_W-1:0]      ptr_q;
  logic                 rstart_q;
  logic                 tmo_pls_q;
  logic [ADDR_WDTH-1:0] raddr_q;
  logic [LEN_WDTH-1:0]  rlen_q;
  logic [TMO_WDTH-1:0]  tmo_cnt_q;

  logic [ADDR_WDTH-1:0] addr_q [NUM_REQ];
  logic [LEN_WDTH-1:0]  len_q  [NUM_REQ];

  logic                 tmo_hit;
  logic                 fin;
  logic [NUM_REQ-1:0]   clr;
  logic [NUM_REQ-1:0]   acc;
  logic [NUM_REQ-1:0]   ovf_set;
  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_sel;
  logic [ID_W-1:0]      ptr_nxt;
  logic [ID_W:0]        idx_w;

  // A finishing slot is released before new starts are judged, so a start
  // coinciding with its own completion is accepted rather than flagged.
  always_comb begin
    tmo_hit = ((state_q == ST_WBUSY) || (state_q == ST_WDONE)) && (tmo_cnt_q == '1);
    fin     = tmo_hit || (state_q == ST_DONE) ||
              ((state_q == ST_ISSUE) && (rlen_q == '0));
    clr     = '0;
    if (fin) clr[gnt_q] = 1'b1;
    acc     = req_start & ~(pend_q & ~clr);
    ovf_set = req_start & pend_q & ~clr;
  end

  // First pending slot at or after ptr_q, searching upward with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(NUM_REQ)) idx_w = idx_w - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && pend_q[idx_w[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_sel   = idx_w[ID_W-1:0];
      end
    end
    ptr_nxt = (gnt_sel == ID_W'(NUM_REQ-1)) ? '0 : gnt_sel + ID_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        addr_q[i] <= req_addr[i*ADDR_WDTH +: ADDR_WDTH];
        len_q[i]  <= req_len[i*LEN_WDTH +: LEN_WDTH];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      done_q    <= '0;
      ovf_q     <= '0;
      tmo_q     <= 1'b0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      rstart_q  <= 1'b0;
      tmo_pls_q <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      tmo_cnt_q <= '0;
    end else if (cfg_rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      done_q    <= '0;
      ovf_q     <= '0;
      tmo_q     <= 1'b0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      rstart_q  <= 1'b0;
      tmo_pls_q <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      pend_q    <= (pend_q & ~clr) | acc;
      ovf_q     <= ovf_q | ovf_set;
      done_q    <= clr;
      tmo_q     <= tmo_q | tmo_hit;
      tmo_pls_q <= tmo_hit;
      rstart_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_found && eng.cfg_ridle) begin
            state_q <= ST_ISSUE;
            gnt_q   <= gnt_sel;
            ptr_q   <= ptr_nxt;
            raddr_q <= addr_q[gnt_sel];
            rlen_q  <= len_q[gnt_sel];
          end
        end
        ST_ISSUE: begin
          if (rlen_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            rstart_q  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= ST_WBUSY;
          end
        end
        ST_WBUSY: begin
          if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_WDTH'(1);
            if (!eng.cfg_ridle) state_q <= ST_WDONE;
          end
        end
        ST_WDONE: begin
          if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_WDTH'(1);
            if (eng.cfg_ridle) state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_pend          = pend_q;
  assign req_done          = done_q;
  assign sts_ovf           = ovf_q;
  assign sts_tmo           = tmo_q;
  assign sts_gnt_id        = gnt_q;
  assign eng.cfg_rstart    = rstart_q;
  assign eng.cfg_raddr     = raddr_q;
  assign eng.cfg_rlen      = rlen_q;
  assign eng.cfg_rsoft_rst = cfg_rst | tmo_pls_q;

endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed bench for dma_rd_arb: single transfer, round-robin order, overflow,
// zero length, timeout and soft reset, against a small behavioural engine.
module tb_dma_rd_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int TW = 5;

  logic            sys_clk;
  logic            sys_rst_n;
  logic            cfg_rst;
  logic [NR-1:0]   req_start;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]   req_pend;
  logic [NR-1:0]   req_done;
  logic [NR-1:0]   sts_ovf;
  logic            sts_tmo;
  logic [1:0]      sts_gnt_id;

  dma_rd_arb_if #(.ADDR_WDTH(AW), .LEN_WDTH(LW)) eng_if ();

  dma_rd_arb #(
    .NUM_REQ   (NR),
    .LEN_WDTH  (LW),
    .ADDR_WDTH (AW),
    .TMO_WDTH  (TW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_rst    (cfg_rst),
    .req_start  (req_start),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_pend   (req_pend),
    .req_done   (req_done),
    .sts_ovf    (sts_ovf),
    .sts_tmo    (sts_tmo),
    .sts_gnt_id (sts_gnt_id),
    .eng        (eng_if)
  );

  int          n_vec;
  int          n_miss;
  int          n_rs;
  logic [1:0]  gnt_log  [64];
  logic [31:0] addr_log [64];
  int          done_cnt [NR];
  int          eng_busy;
  bit          eng_hang;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rs = 0;
    for (int i = 0; i < NR; i++) done_cnt[i] = 0;
  end

  // Record every engine start (grant id and address) and every done pulse.
  always @(negedge sys_clk) begin
    if (eng_if.cfg_rstart && n_rs < 64) begin
      gnt_log[n_rs]  <= sts_gnt_id;
      addr_log[n_rs] <= eng_if.cfg_raddr;
      n_rs           <= n_rs + 1;
    end
    for (int i = 0; i < NR; i++)
      if (req_done[i]) done_cnt[i] <= done_cnt[i] + 1;
  end

  // Engine model: drops idle two cycles after a start, stays busy eng_busy
  // cycles (or until eng_hang is released), then returns to idle.
  initial begin
    eng_if.cfg_ridle = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      if (eng_if.cfg_rstart) begin
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        eng_if.cfg_ridle = 1'b0;
        if (eng_hang) begin
          while (eng_hang) begin
            @(posedge sys_clk); #1;
          end
        end else begin
          repeat (eng_busy) begin
            @(posedge sys_clk); #1;
          end
        end
        eng_if.cfg_ridle = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic wait_done(input int max, output int cyc, output logic [NR-1:0] dn);
    cyc = 0;
    dn  = '0;
    while (cyc < max && dn == '0) begin
      tick();
      cyc++;
      dn = req_done;
    end
  endtask

  int              cyc;
  logic [NR-1:0]   dn;
  int              rs0;
  int              d2;
  int              dsum;
  logic [1:0]      exp_order [6];

  initial begin
    n_vec = 0; n_miss = 0;
    cfg_rst = 1'b0; req_start = '0; req_addr = '0; req_len = '0;
    eng_busy = 3; eng_hang = 1'b0;
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    tick(); tick();
    chk("rst_pend", req_pend, 0);
    chk("rst_done", req_done, 0);
    chk("rst_ovf", sts_ovf, 0);
    chk("rst_tmo", sts_tmo, 0);
    chk("rst_gnt", sts_gnt_id, 0);
    chk("rst_rstart", eng_if.cfg_rstart, 0);
    chk("rst_raddr", eng_if.cfg_raddr, 0);
    chk("rst_rsoft", eng_if.cfg_rsoft_rst, 0);
    sys_rst_n = 1'b1;
    tick();

    // 1: single transfer, 3-cycle start latency
    set_slot(0, 32'h9000_0000, 32'h400);
    eng_busy = 20; rs0 = n_rs;
    req_start = 4'b0001; tick(); req_start = '0;
    chk("t1_pend", req_pend, 4'b0001);
    chk("t1_rstart_c1", eng_if.cfg_rstart, 0);
    tick();
    chk("t1_rstart_c2", eng_if.cfg_rstart, 0);
    tick();
    chk("t1_rstart_c3", eng_if.cfg_rstart, 1);
    chk("t1_raddr", eng_if.cfg_raddr, 32'h9000_0000);
    chk("t1_rlen", eng_if.cfg_rlen, 32'h400);
    chk("t1_gnt", sts_gnt_id, 0);
    tick();
    chk("t1_rstart_pulse", eng_if.cfg_rstart, 0);
    wait_done(60, cyc, dn);
    chk("t1_done", dn, 4'b0001);
    chk("t1_done_cyc", cyc, 23);
    chk("t1_pend_clr", req_pend, 0);
    chk("t1_nrstart", n_rs - rs0, 1);
    tick();
    chk("t1_done_pulse", req_done, 0);

    cfg_rst = 1'b1; #1;
    chk("srst_rsoft_hi", eng_if.cfg_rsoft_rst, 1);
    tick(); cfg_rst = 1'b0; #1;
    chk("srst_rsoft_lo", eng_if.cfg_rsoft_rst, 0);

    // 2: round robin, re-requests landing on their own done pulses
    for (int i = 0; i < NR; i++) set_slot(i, 32'((i + 1) << 28), 32'(16 * (i + 1)));
    eng_busy = 3; rs0 = n_rs;
    req_start = 4'b1111; tick(); req_start = '0;
    wait_done(60, cyc, dn); chk("t2_done0", dn, 4'b0001);
    wait_done(60, cyc, dn); chk("t2_done1", dn, 4'b0010);
    req_start = 4'b0010; tick(); req_start = '0;
    chk("t2_reacc_ovf", sts_ovf, 0);
    chk("t2_reacc_pend", req_pend, 4'b1110);
    wait_done(60, cyc, dn); chk("t2_done2", dn, 4'b0100);
    wait_done(60, cyc, dn); chk("t2_done3", dn, 4'b1000);
    req_start = 4'b1000; tick(); req_start = '0;
    wait_done(60, cyc, dn); chk("t2_done4", dn, 4'b0010);
    wait_done(60, cyc, dn); chk("t2_done5", dn, 4'b1000);
    chk("t2_nrstart", n_rs - rs0, 6);
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
    exp_order[3] = 2'd3; exp_order[4] = 2'd1; exp_order[5] = 2'd3;
    for (int k = 0; k < 6; k++)
      chk($sformatf("t2_gnt%0d", k), gnt_log[rs0 + k], exp_order[k]);
    chk("t2_addr2", addr_log[rs0 + 2], 32'h3000_0000);

    // 3: overflow keeps the first request
    set_slot(2, 32'hB000_0000, 32'h80);
    rs0 = n_rs; d2 = done_cnt[2];
    req_start = 4'b0100; tick(); req_start = '0;
    chk("t3_pend", req_pend, 4'b0100);
    set_slot(2, 32'hA000_0000, 32'h99);
    req_start = 4'b0100; tick(); req_start = '0;
    chk("t3_ovf", sts_ovf, 4'b0100);
    wait_done(60, cyc, dn); chk("t3_done", dn, 4'b0100);
    repeat (12) tick();
    chk("t3_ndone", done_cnt[2] - d2, 1);
    chk("t3_nrstart", n_rs - rs0, 1);
    chk("t3_addr", addr_log[rs0], 32'hB000_0000);
    chk("t3_pend_clr", req_pend, 0);

    // 4: zero length bypasses the engine
    set_slot(0, 32'hC000_0000, 32'h0);
    rs0 = n_rs;
    req_start = 4'b0001; tick(); req_start = '0;
    wait_done(3, cyc, dn);
    chk("t4_done", dn, 4'b0001);
    chk("t4_done_cyc", cyc, 2);
    tick();
    chk("t4_done_pulse", req_done, 0);
    chk("t4_nrstart", n_rs - rs0, 0);

    // 5: engine hangs, watchdog fires, next pending slot served
    set_slot(1, 32'h5100_0000, 32'h40);
    set_slot(3, 32'h5300_0000, 32'h8);
    eng_hang = 1'b1; eng_busy = 3; rs0 = n_rs;
    req_start = 4'b1010; tick(); req_start = '0;
    tick(); tick();
    chk("t5_rstart", eng_if.cfg_rstart, 1);
    chk("t5_gnt", sts_gnt_id, 1);
    cyc = 0;
    while (cyc < 100 && !sts_tmo) begin
      tick(); cyc++;
    end
    chk("t5_tmo_cyc", cyc, 32);
    chk("t5_tmo", sts_tmo, 1);
    chk("t5_rsoft", eng_if.cfg_rsoft_rst, 1);
    chk("t5_done", req_done, 4'b0010);
    chk("t5_pend", req_pend, 4'b1000);
    eng_hang = 1'b0;
    tick();
    chk("t5_rsoft_pulse", eng_if.cfg_rsoft_rst, 0);
    chk("t5_done_pulse", req_done, 0);
    chk("t5_tmo_sticky", sts_tmo, 1);
    wait_done(60, cyc, dn); chk("t5_next_done", dn, 4'b1000);
    chk("t5_next_gnt", gnt_log[rs0 + 1], 3);
    chk("t5_nrstart", n_rs - rs0, 2);

    // 6: soft reset while waiting for the engine to finish
    set_slot(2, 32'h6200_0000, 32'h100);
    eng_hang = 1'b1;
    req_start = 4'b0100; tick(); req_start = '0;
    tick(); tick();
    chk("t6_rstart", eng_if.cfg_rstart, 1);
    repeat (5) tick();
    chk("t6_pend_busy", req_pend, 4'b0100);
    chk("t6_ovf_before", sts_ovf, 4'b0100);
    dsum = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    cfg_rst = 1'b1; #1;
    chk("t6_rsoft_hi", eng_if.cfg_rsoft_rst, 1);
    tick(); cfg_rst = 1'b0; #1;
    chk("t6_rsoft_lo", eng_if.cfg_rsoft_rst, 0);
    chk("t6_pend", req_pend, 0);
    chk("t6_ovf", sts_ovf, 0);
    chk("t6_tmo", sts_tmo, 0);
    chk("t6_gnt", sts_gnt_id, 0);
    chk("t6_raddr", eng_if.cfg_raddr, 0);
    chk("t6_rlen", eng_if.cfg_rlen, 0);
    chk("t6_done", req_done, 0);
    eng_hang = 1'b0;
    repeat (8) tick();
    chk("t6_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - dsum, 0);
    set_slot(0, 32'h7000_0000, 32'h20);
    set_slot(3, 32'h7300_0000, 32'h20);
    eng_busy = 3; rs0 = n_rs;
    req_start = 4'b1001; tick(); req_start = '0;
    wait_done(60, cyc, dn); chk("t6_done_first", dn, 4'b0001);
    chk("t6_gnt_first", gnt_log[rs0], 0);
    wait_done(60, cyc, dn); chk("t6_done_second", dn, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
